serial_operand_serializer: RTL and testbench
============================================

# serial_operand_serializer

- Parallel-to-serial front end for the bit-serial Mealy adder.
- Accepts operand pairs (op_a, op_b) over a valid/ready handshake and shifts them out LSB-first, one bit pair per enabled clock.
- Provides frame markers (first_bit, last_bit) so the adder can clear its carry state at frame start and the downstream collector can close the result at frame end.
- Sits directly upstream of the serial adder; its a_bit/b_bit outputs drive the adder's a/b inputs.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair on op_a/op_b is valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- op_a  input  WIDTH  operand A, parallel.
- op_b  input  WIDTH  operand B, parallel.
- ser_en  input  1  downstream advance enable; low stalls the serial stream.
- a_bit  output  1  current serial bit of A.
- b_bit  output  1  current serial bit of B.
- bit_valid  output  1  a_bit/b_bit are valid and consumed this cycle.
- first_bit  output  1  current bit is bit 0 (LSB) of a frame.
- last_bit  output  1  current bit is bit WIDTH-1 (MSB) of a frame.
- busy  output  1  a frame is in progress.

## Operation
- States: IDLE, SHIFT.
- Registers:
  - sh_a, sh_b: WIDTH-bit shift registers.
  - cnt: bit index, $clog2(WIDTH) bits.
  - Optional hold_a, hold_b, hold_valid (see Configuration).
- Handshake:
  - A transfer occurs on a rising edge when in_valid && in_ready.
  - op_a/op_b are sampled only at that edge.
  - in_valid may drop without a transfer; nothing is captured.
- IDLE:
  - in_ready=1.
  - On transfer: sh_a<=op_a, sh_b<=op_b, cnt<=0, go to SHIFT.
- SHIFT:
  - a_bit=sh_a[0], b_bit=sh_b[0], busy=1.
  - bit_valid=ser_en.
  - first_bit=(cnt==0)&&ser_en.
  - last_bit=(cnt==WIDTH-1)&&ser_en.
- SHIFT with ser_en=1 and cnt<WIDTH-1: shift both registers right by one (zero fill), cnt<=cnt+1.
- SHIFT with ser_en=1 and cnt==WIDTH-1 (frame end):
  - If a next pair is available (Configuration), load it, cnt<=0, stay in SHIFT.
  - Otherwise go to IDLE.
- SHIFT with ser_en=0: all registers hold; a_bit/b_bit remain stable; bit_valid, first_bit and last_bit are 0.
- In IDLE: a_bit, b_bit, bit_valid, first_bit, last_bit and busy are all 0.
- Reset:
  - state=IDLE; sh_a, sh_b, cnt, hold registers and hold_valid all cleared.
  - in_ready is forced to 0 while reset is high.
  - Reset mid-frame discards the frame and any held pair; no last_bit is emitted for it.

## Timing
- Acceptance to first bit: 1 cycle; first_bit is asserted in the cycle after the transfer edge, given ser_en=1.
- A frame occupies exactly WIDTH cycles with ser_en=1; ser_en=0 cycles stretch the frame one-for-one.
- Without prefetch:
  - Throughput is one frame per WIDTH+1 cycles.
  - in_ready=0 throughout SHIFT, including the last-bit cycle.
- All outputs are functions of registered state and ser_en only; there is no combinational path from op_a/op_b or in_valid.

## Configuration
- Macro: SERIALIZER_PREFETCH_EN.
- Defined: adds a one-entry holding buffer (hold_a, hold_b, hold_valid).
  - in_ready = !hold_valid.
  - A transfer during SHIFT writes the hold buffer.
  - A transfer in IDLE loads sh_a/sh_b directly.
  - At frame end with hold_valid=1: hold moves into sh_a/sh_b and hold_valid<=0.
  - At frame end with hold_valid=0 and a simultaneous transfer: the pair bypasses directly into sh_a/sh_b.
  - Either case gives back-to-back frames with no bubble: first_bit immediately follows last_bit.
- Undefined: no hold registers; behaviour is exactly as described for the no-prefetch case.

## Test plan
- Single frame: WIDTH=8, op_a=8'hA5, op_b=8'h3C, ser_en=1.
  - a_bit sequence 1,0,1,0,0,1,0,1; b_bit sequence 0,0,1,1,1,1,0,0.
  - first_bit on cycle 1, last_bit on cycle 8; IDLE and in_ready=1 on cycle 9.
- Stall: same operands, ser_en=0 for 3 cycles after bit 3.
  - a_bit holds at 0 and bit_valid=0 for those 3 cycles.
  - Sequence resumes unchanged; the frame lasts 11 cycles.
- Back-to-back:
  - 8'hFF/8'h01 then 8'h00/8'hFF with in_valid held high.
  - With SERIALIZER_PREFETCH_EN: 16 consecutive bit_valid cycles, first_bit directly after last_bit.
  - Without the macro: a one-cycle gap with bit_valid=0 between frames.
- Prefetch full:
  - With the macro, present a third pair while the hold buffer is occupied.
  - in_ready=0 until the cycle after the current frame's last_bit; no pair is lost or duplicated.
- Reset mid-frame: assert reset at bit 4.
  - Next cycle all outputs are 0, hold_valid=0, and in_ready=1 after reset deasserts.
  - A new pair 8'h0F/8'hF0 serializes correctly from bit 0.
- Handshake without transfer: in_valid pulses while in_ready=0.
  - No state change; operands are ignored.

Source files
------------

// File: rtl/serial_operand_serializer.sv
// Parallel-to-serial operand front end for the bit-serial adder; shifts op_a/op_b out LSB-first
// with first/last frame markers. 1 cycle from accept to first bit; ser_en low freezes the stream.
// Optional macro SERIALIZER_PREFETCH_EN adds a one-entry hold buffer for bubble-free back-to-back frames.
module serial_operand_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             ser_en,
    output logic             a_bit,
    output logic             b_bit,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic             transfer;
    logic             frame_end;
    logic             load_op;
    logic             do_shift;

`ifdef SERIALIZER_PREFETCH_EN
    logic [WIDTH-1:0] hold_a;
    logic [WIDTH-1:0] hold_b;
    logic             hold_valid;
    logic             hold_wr;
    logic             hold_clr;
    logic             load_hold;
`endif

    always_comb begin
        state_nxt = state;
        load_op   = 1'b0;
        do_shift  = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        bit_valid = 1'b0;
        first_bit = 1'b0;
        last_bit  = 1'b0;
        busy      = 1'b0;
`ifdef SERIALIZER_PREFETCH_EN
        hold_wr   = 1'b0;
        hold_clr  = 1'b0;
        load_hold = 1'b0;
        in_ready  = !reset && !hold_valid;
`else
        in_ready  = !reset && (state == IDLE);
`endif
        transfer  = in_valid && in_ready;
        frame_end = (state == SHIFT) && ser_en && (cnt == LAST);

        case (state)
            IDLE: begin
                if (transfer) begin
                    load_op   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                a_bit     = sh_a[0];
                b_bit     = sh_b[0];
                busy      = 1'b1;
                bit_valid = ser_en;
                first_bit = ser_en && (cnt == '0);
                last_bit  = frame_end;
                if (frame_end) begin
`ifdef SERIALIZER_PREFETCH_EN
                    // Held pair wins; otherwise a same-cycle transfer bypasses the hold buffer.
                    if (hold_valid) begin
                        load_hold = 1'b1;
                        hold_clr  = 1'b1;
                    end else if (transfer) begin
                        load_op = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
`else
                    state_nxt = IDLE;
`endif
                end else if (ser_en) begin
                    do_shift = 1'b1;
                end
`ifdef SERIALIZER_PREFETCH_EN
                hold_wr = transfer && !frame_end;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_a <= '0;
            sh_b <= '0;
            cnt  <= '0;
        end else if (load_op) begin
            sh_a <= op_a;
            sh_b <= op_b;
            cnt  <= '0;
`ifdef SERIALIZER_PREFETCH_EN
        end else if (load_hold) begin
            sh_a <= hold_a;
            sh_b <= hold_b;
            cnt  <= '0;
`endif
        end else if (do_shift) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            cnt  <= cnt + 1'b1;
        end
    end

`ifdef SERIALIZER_PREFETCH_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_a     <= '0;
            hold_b     <= '0;
            hold_valid <= 1'b0;
        end else if (hold_wr) begin
            hold_a     <= op_a;
            hold_b     <= op_b;
            hold_valid <= 1'b1;
        end else if (hold_clr) begin
            hold_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Bench for serial_operand_serializer: vector table, directed multi-cycle sequences and random stimulus
// compared against a word/index/queue reference model; honours SERIALIZER_PREFETCH_EN.
module tb_serial_operand_serializer;
    localparam int W = 8;
`ifdef SERIALIZER_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         ser_en;
    logic         a_bit, b_bit, bit_valid, first_bit, last_bit, busy;

    serial_operand_serializer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .ser_en(ser_en),
        .a_bit(a_bit), .b_bit(b_bit), .bit_valid(bit_valid),
        .first_bit(first_bit), .last_bit(last_bit), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: current frame as whole words plus bit index, pending pairs in a queue.
    bit           m_active;
    logic [W-1:0] m_a, m_b;
    int           m_idx;
    logic [W-1:0] pq_a[$];
    logic [W-1:0] pq_b[$];
    bit           last_xfer;
    logic [6:0]   last_obs;   // {a,b,bit_valid,first,last,busy,in_ready}

    function automatic logic [6:0] model_out(input bit rst, input bit se);
        logic a, b, bv, fb, lb, bz, rdy;
        a   = m_active ? m_a[m_idx] : 1'b0;
        b   = m_active ? m_b[m_idx] : 1'b0;
        bv  = m_active && se;
        fb  = bv && (m_idx == 0);
        lb  = bv && (m_idx == W - 1);
        bz  = m_active;
        rdy = rst ? 1'b0 : (PF ? (pq_a.size() == 0) : !m_active);
        return {a, b, bv, fb, lb, bz, rdy};
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d want %0d", nm, $time, got, want);
        end
    endtask

    task automatic step(input bit rst, input bit iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit se, input string nm);
        logic [6:0] exp;
        logic [6:0] obs;
        bit xfer;
        bit consumed;
        @(posedge clk);
        #1;
        reset = rst; in_valid = iv; op_a = a; op_b = b; ser_en = se;
        @(negedge clk);
        exp = model_out(rst, se);
        obs = {a_bit, b_bit, bit_valid, first_bit, last_bit, busy, in_ready};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: outputs got %b want %b", nm, $time, obs, exp);
        end
        last_obs = obs;
        xfer = iv && exp[0];
        consumed = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_idx = 0;
            pq_a.delete();
            pq_b.delete();
            xfer = 1'b0;
        end else begin
            if (m_active && se) begin
                if (m_idx == W - 1) begin
                    if (pq_a.size() > 0) begin
                        m_a = pq_a.pop_front();
                        m_b = pq_b.pop_front();
                        m_idx = 0;
                    end else if (xfer) begin
                        m_a = a; m_b = b; m_idx = 0; consumed = 1'b1;
                    end else begin
                        m_active = 1'b0;
                    end
                end else begin
                    m_idx++;
                end
            end else if (!m_active && xfer) begin
                m_a = a; m_b = b; m_idx = 0; m_active = 1'b1; consumed = 1'b1;
            end
            if (xfer && !consumed) begin
                pq_a.push_back(a);
                pq_b.push_back(b);
            end
        end
        last_xfer = xfer;
    endtask

    // Streams up to three pairs with in_valid held high and ser_en=1, then checks the serial data.
    logic [W-1:0] sa[3];
    logic [W-1:0] sb[3];
    int run1, gap, run2, nlast, lbc[3], xc[3];
    task automatic stream(input int n, input string nm);
        int k;
        int nb;
        int phase;
        logic [W-1:0] ra, rb;
        int fi;
        k = 0; nb = 0; nlast = 0; fi = 0; phase = 0;
        run1 = 0; gap = 0; run2 = 0;
        ra = '0; rb = '0;
        for (int c = 0; c < 40; c++) begin
            step(1'b0, k < n, sa[(k < n) ? k : 0], sb[(k < n) ? k : 0], 1'b1, nm);
            if ((k < n) && last_obs[0]) xc[k] = c;
            if (last_xfer) k++;
            if (last_obs[4]) begin
                ra[nb] = last_obs[6];
                rb[nb] = last_obs[5];
                nb++;
                if (phase == 0) phase = 1;
                if (phase == 1) run1++;
                if (phase == 2) begin phase = 3; end
                if (phase == 3) run2++;
            end else if (phase == 1 || phase == 2) begin
                phase = 2;
                gap++;
            end
            if (last_obs[2]) begin
                if (nlast < 3) lbc[nlast] = c;
                nlast++;
            end
            if (nb == W) begin
                if (fi < n) begin
                    chk({nm, "_word_a"}, int'(ra), int'(sa[fi]));
                    chk({nm, "_word_b"}, int'(rb), int'(sb[fi]));
                end
                fi++;
                nb = 0;
            end
        end
        chk({nm, "_frames"}, nlast, n);
        chk({nm, "_accepted"}, k, n);
    endtask

    typedef struct {
        bit         iv;
        logic [7:0] a;
        logic [7:0] b;
        bit         se;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];
    int a_seq[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int b_seq[8] = '{0, 0, 1, 1, 1, 1, 0, 0};

    task automatic addv(input bit iv, input logic [7:0] a, input logic [7:0] b, input bit se,
                        input int ea, input int eb, input bit bv, input bit fb, input bit lb,
                        input bit bz, input bit rdy);
        vec_t v;
        v.iv = iv; v.a = a; v.b = b; v.se = se;
        v.exp = {ea[0], eb[0], bv, fb, lb, bz, rdy};
        tbl.push_back(v);
    endtask

    initial begin
        bit rdy_sh;
        logic [W-1:0] ra, rb;
        rdy_sh = PF;
        m_active = 1'b0; m_idx = 0; m_a = '0; m_b = '0;
        reset = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; ser_en = 1'b0;
        repeat (2) @(posedge clk);
        step(1'b1, 1'b1, 8'h11, 8'h22, 1'b1, "reset_hold");
        chk("reset_in_ready", int'(last_obs[0]), 0);

        // Single frame, then the same operands with a 3-cycle stall after bit 3.
        addv(1, 8'hA5, 8'h3C, 1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            addv(0, 8'h00, 8'h00, 1, a_seq[i], b_seq[i], 1, i == 0, i == 7, 1, rdy_sh);
        addv(1, 8'hA5, 8'h3C, 1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            addv(0, 8'h00, 8'h00, 1, a_seq[i], b_seq[i], 1, i == 0, 0, 1, rdy_sh);
        for (int i = 0; i < 3; i++)
            addv(0, 8'h00, 8'h00, 0, a_seq[4], b_seq[4], 0, 0, 0, 1, rdy_sh);
        for (int i = 4; i < 8; i++)
            addv(0, 8'h00, 8'h00, 1, a_seq[i], b_seq[i], 1, 0, i == 7, 1, rdy_sh);
        addv(0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            step(1'b0, tbl[i].iv, tbl[i].a, tbl[i].b, tbl[i].se, "table_model");
            chk($sformatf("table_row%0d", i), int'(last_obs), int'(tbl[i].exp));
        end

        // Back-to-back pairs: 16-cycle run with prefetch, 8 + gap 1 + 8 without.
        sa[0] = 8'hFF; sb[0] = 8'h01; sa[1] = 8'h00; sb[1] = 8'hFF;
        stream(2, "b2b");
        chk("b2b_run1", run1, PF ? 16 : 8);
        chk("b2b_gap", gap, PF ? 0 : 1);
        chk("b2b_run2", run2, PF ? 0 : 8);

        // Third pair waits for the hold buffer (prefetch) or for IDLE (no prefetch).
        sa[0] = 8'hAA; sb[0] = 8'h55; sa[1] = 8'h0F; sb[1] = 8'hF0; sa[2] = 8'h3C; sb[2] = 8'hC3;
        stream(3, "pf_full");
        chk("pf_full_third_accept", xc[2], PF ? lbc[0] + 1 : lbc[1] + 1);

        // Reset at bit 4 with a second pair offered (held under prefetch) is fully discarded.
        step(1'b0, 1'b1, 8'hA5, 8'h3C, 1'b1, "rst_load");
        step(1'b0, 1'b1, 8'h77, 8'h88, 1'b1, "rst_b0");
        for (int i = 1; i < 4; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "rst_bits");
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, "rst_assert");
        chk("rst_ready_low", int'(last_obs[0]), 0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "rst_after");
        chk("rst_after_outputs", int'(last_obs), 1);
        sa[0] = 8'h0F; sb[0] = 8'hF0;
        stream(1, "post_rst");

        // in_valid pulses while in_ready is low must not change the frame.
        step(1'b0, 1'b1, 8'hC3, 8'h5A, 1'b1, "nx_load");
        if (PF) step(1'b0, 1'b1, 8'h96, 8'h69, 1'b1, "nx_fill");
        ra = '0; rb = '0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, i[0], 8'hEE, 8'h11, 1'b1, "nx_pulse");
            if (!PF && i < 7 && last_obs[4]) begin ra[i + 1] = last_obs[6]; rb[i + 1] = last_obs[5]; end
        end
        repeat (12) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "nx_drain");

        // Random traffic, stalls and occasional reset.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
                 W'($urandom), W'($urandom), $urandom_range(0, 3) != 0, "random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
